// File: rtl/nibble_div_pkg.sv
// Shared types and default widths for the nibble divider.
package nibble_div_pkg;

    localparam int DIVIDEND_W_DEF = 8;
    localparam int DIVISOR_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_div_step.sv
// One restoring-division step: compare the shifted partial remainder
// against the divisor and subtract when it fits.
module nibble_div_step #(
    parameter int W = 4
) (
    input  logic [W:0]   i_rem,
    input  logic [W-1:0] i_dvs,
    output logic [W:0]   o_rem,
    output logic         o_qbit
);

    logic [W:0] w_dvs_ext;
    logic       w_ge;

    assign w_dvs_ext = {1'b0, i_dvs};
    assign w_ge      = (i_rem >= w_dvs_ext);
    assign o_qbit    = w_ge;
    assign o_rem     = w_ge ? (i_rem - w_dvs_ext) : i_rem;

endmodule

// File: rtl/nibble_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, MSB first.
// Define NIBBLE_DIV_ZERO_DETECT_EN to short-cut zero divisors with div_zero.
module nibble_divider
    import nibble_div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [DIVIDEND_W-1:0] r_dvd;
    logic [DIVISOR_W-1:0]  r_dvs;
    logic [DIVISOR_W:0]    r_prem;
    logic [DIVIDEND_W-1:0] r_q;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVIDEND_W-1:0] r_quot;
    logic [DIVISOR_W-1:0]  r_rem;

    logic [DIVISOR_W:0]    w_shift;
    logic [DIVISOR_W:0]    w_next;
    logic                  w_qbit;
    logic [DIVIDEND_W-1:0] w_q_next;

    // Top bit of the partial remainder falls off as the next dividend bit enters
    assign w_shift  = (DIVISOR_W+1)'({r_prem, r_dvd[DIVIDEND_W-1]});
    assign w_q_next = DIVIDEND_W'({r_q, w_qbit});

    nibble_div_step #(
        .W (DIVISOR_W)
    ) u_step (
        .i_rem  (w_shift),
        .i_dvs  (r_dvs),
        .o_rem  (w_next),
        .o_qbit (w_qbit)
    );

`ifdef NIBBLE_DIV_ZERO_DETECT_EN
    logic r_dz;
    logic r_zpend;
    assign div_zero = r_dz;
`else
    assign div_zero = 1'b0;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quot;
    assign remainder = r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_prem  <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
`ifdef NIBBLE_DIV_ZERO_DETECT_EN
            r_dz    <= 1'b0;
            r_zpend <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_dvd   <= dividend;
                        r_dvs   <= divisor;
                        r_prem  <= '0;
                        r_q     <= '0;
                        r_cnt   <= CNT_W'(DIVIDEND_W - 1);
`ifdef NIBBLE_DIV_ZERO_DETECT_EN
                        r_zpend <= (divisor == '0);
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
`ifdef NIBBLE_DIV_ZERO_DETECT_EN
                    if (r_zpend) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_quot  <= '1;
                        r_rem   <= '0;
                        r_dz    <= 1'b1;
                        r_zpend <= 1'b0;
                    end else
`endif
                    begin
                        r_prem <= w_next;
                        r_dvd  <= r_dvd << 1;
                        r_q    <= w_q_next;
                        if (r_cnt == '0) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_quot  <= w_q_next;
                            r_rem   <= w_next[DIVISOR_W-1:0];
`ifdef NIBBLE_DIV_ZERO_DETECT_EN
                            r_dz    <= 1'b0;
`endif
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_divider.sv
// Directed bench for nibble_divider: vector table plus reset, back-to-back
// and busy-start sequences. Honours NIBBLE_DIV_ZERO_DETECT_EN.
module tb_nibble_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] dvd;
        logic [3:0] dvs;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t vecs[9];

    nibble_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive operands for one edge; returns just after the accepting edge
    task automatic start_op(input logic [7:0] a, input logic [3:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (done) break;
        end
        if (!done) begin
            k = -1;
            check("done_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        int k;
        int extra;

        vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 8};
        vecs[1] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 8};
        vecs[2] = '{8'd5,   4'd9,  8'd0,   4'd5,  1'b0, 8};
        vecs[3] = '{8'd100, 4'd10, 8'd10,  4'd0,  1'b0, 8};
        vecs[4] = '{8'd13,  4'd15, 8'd0,   4'd13, 1'b0, 8};
        vecs[5] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 8};
        vecs[6] = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0, 8};
        vecs[7] = '{8'd0,   4'd3,  8'd0,   4'd0,  1'b0, 8};
`ifdef NIBBLE_DIV_ZERO_DETECT_EN
        vecs[8] = '{8'h96,  4'd0,  8'hFF,  4'd0,  1'b1, 1};
`else
        vecs[8] = '{8'h96,  4'd0,  8'hFF,  4'd6,  1'b0, 8};
`endif

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #23;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quot", quotient, 0);
        check("rst_rem", remainder, 0);
        check("rst_dz", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].dvd, vecs[i].dvs);
            if (vecs[i].dvs != 0) check($sformatf("v%0d_busy", i), busy, 1);
            wait_done(k);
            check($sformatf("v%0d_lat", i), k, vecs[i].lat);
            check($sformatf("v%0d_quot", i), quotient, vecs[i].q);
            check($sformatf("v%0d_rem", i), remainder, vecs[i].r);
            check($sformatf("v%0d_dz", i), div_zero, vecs[i].dz);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pulse", i), done, 0);
            check($sformatf("v%0d_idle", i), busy, 0);
            check($sformatf("v%0d_hold", i), quotient, vecs[i].q);
        end

        // Back-to-back: second start lands in the DONE cycle
        start_op(8'd255, 4'd1);
        wait_done(k);
        check("b2b1_lat", k, 8);
        check("b2b1_quot", quotient, 255);
        check("b2b1_rem", remainder, 0);
        start    = 1'b1;
        dividend = 8'd5;
        divisor  = 4'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_done_low", done, 0);
        check("b2b_hold", quotient, 255);
        wait_done(k);
        check("b2b2_lat", k, 8);
        check("b2b2_quot", quotient, 0);
        check("b2b2_rem", remainder, 5);

        // Start pulsed mid-RUN with other operands must be ignored
        start_op(8'd200, 4'd7);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 3) begin
                start    = 1'b1;
                dividend = 8'd17;
                divisor  = 4'd3;
            end
            if (k == 4) start = 1'b0;
            if (done) break;
        end
        start = 1'b0;
        check("ign_lat", k, 8);
        check("ign_quot", quotient, 28);
        check("ign_rem", remainder, 4);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        check("ign_no_rerun", extra, 0);

        // Asynchronous reset in the middle of RUN
        start_op(8'd200, 4'd7);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_quot", quotient, 0);
        check("mrst_rem", remainder, 0);
        check("mrst_dz", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        check("mrst_no_done", extra, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_divider.md
NIBBLE_DIVIDER -- requirements
Module: nibble_divider

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 8, meaning dividend and quotient width in bits.
REQ-002 SHALL have parameter DIVISOR_W, default 4, meaning divisor and remainder width in bits.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; every register is rising-edge triggered on it.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, meaning a request to begin a division.
REQ-006 SHALL have port dividend, input, DIVIDEND_W, meaning the unsigned dividend, sampled when start is accepted.
REQ-007 SHALL have port divisor, input, DIVISOR_W, meaning the unsigned divisor, sampled when start is accepted.
REQ-008 SHALL have port busy, output, 1, meaning a division is in progress.
REQ-009 SHALL have port done, output, 1, meaning a single-cycle pulse that marks the result as valid.
REQ-010 SHALL have port quotient, output, DIVIDEND_W, meaning the unsigned quotient.
REQ-011 SHALL have port remainder, output, DIVISOR_W, meaning the unsigned remainder.
REQ-012 SHALL have port div_zero, output, 1, meaning the divisor was zero; it is valid while done=1 and held afterwards.

Function
REQ-013 SHALL implement a state machine with states IDLE, RUN and DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after DIVIDEND_W steps.
- DONE -> RUN on start=1, otherwise DONE -> IDLE.
REQ-014 SHALL accept start only when busy=0, i.e. in IDLE or DONE.
- On acceptance it captures dividend and divisor, clears the partial remainder, and loads the step counter with DIVIDEND_W-1.
REQ-015 SHALL ignore start while busy=1; operands applied at that time have no effect.
REQ-016 SHALL drive busy=1 in every RUN cycle and busy=0 in IDLE and DONE.
REQ-017 SHALL perform one restoring-division step per RUN cycle, MSB of the dividend first.
- The partial remainder is DIVISOR_W+1 bits wide.
- Each step: shift the remainder left by one, bringing in the next dividend bit.
- If the remainder >= divisor, subtract the divisor and set the quotient bit to 1; otherwise set the quotient bit to 0.
REQ-018 SHALL have a latency of exactly DIVIDEND_W+1 cycles: start accepted at edge N -> done=1 in the cycle after edge N+DIVIDEND_W.
REQ-019 SHALL assert done for exactly one cycle per accepted start.
REQ-020 SHALL update quotient, remainder and div_zero only on the edge that enters DONE, and hold them until the next DONE.
REQ-021 SHALL make back-to-back operation possible: a start accepted in the DONE cycle goes straight to RUN with no IDLE cycle.
REQ-022 SHALL give every result satisfying quotient*divisor+remainder == dividend and remainder < divisor whenever divisor != 0.

Reset
REQ-023 SHALL, while rst_n=0 and independent of clk, force: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, counter=0, partial remainder=0.
REQ-024 SHALL, when reset is asserted mid-RUN, abandon the operation with no done pulse; after release the block waits in IDLE.

Configuration
REQ-025 SHALL provide macro NIBBLE_DIV_ZERO_DETECT_EN.
- Defined: an accepted start with divisor=0 goes directly to DONE on the next edge (2-cycle latency), skips RUN, and returns quotient=all ones, remainder=0, div_zero=1.
- Undefined: divisor=0 runs the normal DIVIDEND_W-step algorithm and yields quotient=all ones, remainder=dividend[DIVISOR_W-1:0]; div_zero is tied to 0.

Structure
REQ-026 SHALL take the state enumeration and the default width constants from shared package nibble_div_pkg.
REQ-027 SHALL place the combinational compare-and-subtract step in one sub-module, nibble_div_step.
- Inputs: partial remainder, divisor.
- Outputs: next remainder, quotient bit.

Verification
REQ-028 SHALL cover reset: rst_n=0 mid-RUN -> busy, done, quotient, remainder and div_zero all 0 immediately, and no done pulse afterwards.
REQ-029 SHALL cover: dividend=200, divisor=7 -> done at edge N+8, quotient=28, remainder=4.
REQ-030 SHALL cover: dividend=255, divisor=1, then back-to-back start in the DONE cycle with dividend=5, divisor=9 -> first result quotient=255, remainder=0; second result quotient=0, remainder=5, with no IDLE cycle between.
REQ-031 SHALL cover: start pulsed during RUN with different operands -> ignored, original result unchanged.
REQ-032 SHALL cover: dividend=0x96, divisor=0.
- With NIBBLE_DIV_ZERO_DETECT_EN: quotient=0xFF, remainder=0, div_zero=1, done at 2 cycles.
- Without it: quotient=0xFF, remainder=6, div_zero=0, done at 9 cycles.
